// File: rtl/rgb128_axis_framer.sv
// rgb128_axis_framer: tags packed 4-pixel words with SOF/EOL and
// streams them out over AXI4-Stream through a small FWFT FIFO.
module rgb128_axis_framer #(
  parameter int H_WORDS    = 480,
  parameter int V_LINES    = 1080,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_vs,
  input  logic         i_de,
  input  logic [127:0] i_tdata,
  output logic [127:0] o_tdata,
  output logic         o_tvalid,
  input  logic         i_tready,
  output logic         o_tuser,
  output logic         o_tlast,
  output logic         o_ovf,
  output logic         o_short
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_WORDS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic [1:0] {
    WAIT_SOF,
    RUN,
    DROP
  } state_t;

  state_t         state;
  logic           vs_d;
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [129:0]   mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  logic           vs_rise;
  logic           empty;
  logic           full;
  logic           open;
  logic           wr_en;
  logic           drop;
  logic           pop;
  logic [XW-1:0]  x_cur;
  logic [YW-1:0]  y_cur;
  logic           last_x;
  logic           last_y;
  logic           sof;
  logic [129:0]   head;

  assign vs_rise = i_vs & ~vs_d;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign open    = (state == RUN) | vs_rise;
  assign x_cur   = vs_rise ? '0 : x_cnt;
  assign y_cur   = vs_rise ? '0 : y_cnt;
  assign last_x  = (x_cur == X_LAST);
  assign last_y  = (y_cur == Y_LAST);
  assign sof     = (x_cur == '0) && (y_cur == '0);
  assign wr_en   = i_de & open & ~full;
  assign drop    = i_de & open & full;
  assign pop     = o_tvalid & i_tready;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign o_tvalid = ~empty;
  assign o_tdata  = empty ? '0 : head[127:0];
  assign o_tuser  = ~empty & head[129];
  assign o_tlast  = ~empty & head[128];

  // Frame state, position counters and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= WAIT_SOF;
      vs_d    <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      o_ovf   <= 1'b0;
      o_short <= 1'b0;
    end else begin
      vs_d <= i_vs;
      if (vs_rise && state == RUN)
        o_short <= 1'b1;
      if (drop) begin
        o_ovf <= 1'b1;
        state <= DROP;
      end else if (wr_en && last_x && last_y) begin
        state <= WAIT_SOF;
      end else if (vs_rise) begin
        state <= RUN;
      end
      if (wr_en) begin
        x_cnt <= last_x ? '0 : x_cur + XW'(1);
        if (last_x)
          y_cnt <= last_y ? '0 : y_cur + YW'(1);
        else
          y_cnt <= y_cur;
      end else if (vs_rise) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end
    end
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage of {sof, eol, data}.
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= {sof, last_x, i_tdata};
  end

endmodule

// File: tb/tb_rgb128_axis_framer.sv
// tb_rgb128_axis_framer: scoreboard bench with a frame-level model
// of tagging, FIFO occupancy, drop and short-frame behaviour.
module tb_rgb128_axis_framer;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 8;
  localparam int M_WAIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_DROP = 2;

  typedef logic [129:0] beat_t;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_vs = 1'b0;
  logic         i_de = 1'b0;
  logic [127:0] i_tdata = '0;
  logic         i_tready = 1'b0;
  logic [127:0] o_tdata;
  logic         o_tvalid;
  logic         o_tuser;
  logic         o_tlast;
  logic         o_ovf;
  logic         o_short;

  always #5 clk = ~clk;

  rgb128_axis_framer #(
    .H_WORDS(H),
    .V_LINES(V),
    .FIFO_DEPTH(D)
  ) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_vs(i_vs),
    .i_de(i_de),
    .i_tdata(i_tdata),
    .o_tdata(o_tdata),
    .o_tvalid(o_tvalid),
    .i_tready(i_tready),
    .o_tuser(o_tuser),
    .o_tlast(o_tlast),
    .o_ovf(o_ovf),
    .o_short(o_short)
  );

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    mode = M_WAIT;
  int    pos = 0;
  int    occ = 0;
  bit    prev_vs = 1'b0;
  bit    e_ovf = 1'b0;
  bit    e_short = 1'b0;
  bit    was_rst = 1'b0;
  bit    mon_en = 1'b0;
  bit    end_chk = 1'b0;
  bit    stalled = 1'b0;
  beat_t held = '0;

  // Apply one cycle of stimulus and advance the reference model.
  task automatic step(input bit rst, input bit vs, input bit de,
                      input logic [127:0] d, input bit rdy);
    int m, p, no;
    bit ov, sh, rise, full, pop;
    i_rst_n = !rst;
    i_vs = vs;
    i_de = de;
    i_tdata = d;
    i_tready = rdy;
    m = mode;
    p = pos;
    ov = e_ovf;
    sh = e_short;
    no = occ;
    if (rst) begin
      m = M_WAIT;
      p = 0;
      ov = 0;
      sh = 0;
      no = 0;
    end else begin
      full = (occ == D);
      pop = (occ > 0) && rdy;
      rise = vs && !prev_vs;
      if (rise) begin
        if (m == M_RUN) sh = 1;
        m = M_RUN;
        p = 0;
      end
      if (de && m == M_RUN) begin
        if (full) begin
          ov = 1;
          m = M_DROP;
        end else begin
          exp_q.push_back({p == 0, (p % H) == H - 1, d});
          no++;
          p++;
          if (p == H * V) begin
            m = M_WAIT;
            p = 0;
          end
        end
      end
      if (pop) no--;
    end
    @(posedge clk);
    mode = m;
    pos = p;
    e_ovf = ov;
    e_short = sh;
    occ = no;
    prev_vs = rst ? 1'b0 : vs;
    was_rst = rst;
    if (rst) exp_q.delete();
    #1;
  endtask

  task automatic frame(input int n, input bit rdy, input int base);
    for (int i = 0; i < n; i++)
      step(0, i == 0, 1, 128'(base + i), rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, '0, rdy);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (exp_q.size() > 0 || occ > 0); i++)
      step(0, 0, 0, '0, 1);
  endtask

  // Monitor: compare DUT outputs against the model away from the edge.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (mon_en) begin
      cur = {o_tuser, o_tlast, o_tdata};
      checks++;
      if (o_tvalid !== (occ > 0)) begin
        failures++;
        $display("FAIL tvalid got=%0b exp=%0b t=%0t",
                 o_tvalid, occ > 0, $time);
      end
      checks++;
      if (o_ovf !== e_ovf) begin
        failures++;
        $display("FAIL ovf got=%0b exp=%0b t=%0t", o_ovf, e_ovf, $time);
      end
      checks++;
      if (o_short !== e_short) begin
        failures++;
        $display("FAIL short got=%0b exp=%0b t=%0t",
                 o_short, e_short, $time);
      end
      if (was_rst) begin
        checks++;
        if (cur !== '0) begin
          failures++;
          $display("FAIL reset_out got=%h exp=0 t=%0t", cur, $time);
        end
      end
      if (stalled && o_tvalid) begin
        checks++;
        if (cur !== held) begin
          failures++;
          $display("FAIL stable got=%h exp=%h t=%0t", cur, held, $time);
        end
      end
      stalled = o_tvalid && !i_tready;
      held = cur;
      if (o_tvalid && i_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL underflow got=%h exp=none t=%0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL beat got=%h exp=%h t=%0t", cur, e, $time);
          end
        end
      end
      if (end_chk) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end
      end
    end
  end

  initial begin
    int thr;
    bit vs, de, rdy;
    step(1, 0, 0, '0, 1);
    step(1, 0, 0, '0, 1);
    mon_en = 1'b1;
    idle(2, 1);
    // small frame tagging
    frame(8, 1, 0);
    drain(10);
    // words before any frame sync are discarded
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 128'(100 + i), 1);
    frame(8, 1, 200);
    drain(10);
    // full backpressure without loss
    frame(8, 0, 300);
    idle(2, 0);
    drain(20);
    // overflow drops the rest of the frame
    frame(12, 0, 400);
    idle(2, 0);
    drain(20);
    frame(8, 1, 500);
    drain(10);
    // short frame, next frame starts with the vs word
    frame(5, 1, 600);
    frame(8, 1, 700);
    drain(10);
    // reset with words queued
    frame(3, 0, 800);
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 128'(900 + i), 1);
    frame(8, 1, 1000);
    drain(10);
    // randomized traffic
    thr = 8;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) thr = $urandom_range(1, 8);
      if ($urandom_range(0, 599) == 0) begin
        step(1, 0, 0, '0, 1);
      end else begin
        vs = ($urandom_range(0, 29) == 0);
        de = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 7) < thr);
        step(0, vs, de, {$urandom, $urandom, $urandom, $urandom}, rdy);
      end
    end
    drain(100);
    end_chk = 1'b1;
    idle(1, 1);
    end_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb128_axis_framer.md
# rgb128_axis_framer

Downstream stage of the 4-pixel RGB888→128-bit packer. Takes the packed 128-bit pixel words (4 × {8'h00,R,G,B}) from the sensor-timed video path, which has no backpressure, and delivers them as an AXI4-Stream. The stream carries SOF on `o_tuser` and EOL on `o_tlast`, both generated from internal column/line counters. An internal FIFO absorbs consumer stalls. On overflow, the rest of the frame is dropped so the consumer (VDMA / UDP packetizer) never sees a torn frame.

## Interface
Parameters:
- `H_WORDS`, 480, 128-bit words per line (1920 px / 4)
- `V_LINES`, 1080, lines per frame
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥4

Ports:
- `i_clk` in 1: single clock for the whole block
- `i_rst_n` in 1: reset, synchronous, active-low
- `i_vs` in 1: frame sync level; a rising edge starts a frame
- `i_de` in 1: `i_tdata` valid this cycle
- `i_tdata` in 128: packed pixel word, pixel 0 in [31:0]
- `o_tdata` out 128: stream data
- `o_tvalid` out 1: stream valid
- `i_tready` in 1: stream ready
- `o_tuser` out 1: high on the first word of a frame
- `o_tlast` out 1: high on the last word of each line
- `o_ovf` out 1: sticky, set when a word is dropped because the FIFO is full
- `o_short` out 1: sticky, set when `i_vs` rises before a frame completes

## Operation
- **VS edge:** `vs_d` is registered from `i_vs`. `vs_rise = i_vs & ~vs_d`.
- **Counters:**
  - `x_cnt` runs 0..H_WORDS-1 and `y_cnt` runs 0..V_LINES-1. Both advance only on an accepted write.
  - `x_cnt` wraps to 0 after H_WORDS-1 and then `y_cnt` increments.
  - `vs_rise` clears both counters.
- **Sideband tagging at write time:** each FIFO entry stores 130 bits, {sof, eol, data}.
  - `sof = (x_cnt==0 && y_cnt==0)`
  - `eol = (x_cnt==H_WORDS-1)`
- **State machine:**
  - **WAIT_SOF** (reset state): all `i_de` words are discarded. `vs_rise` → RUN.
  - **RUN:**
    - `i_de && !full`: write the entry and advance the counters.
    - Write of the last frame word (x=H_WORDS-1, y=V_LINES-1) → WAIT_SOF.
    - `i_de && full`: discard the word, set `o_ovf`, go to DROP.
    - `vs_rise` before frame end: set `o_short`, clear the counters, stay in RUN.
  - **DROP:** all `i_de` words are discarded. `vs_rise` → RUN with the counters cleared.
- **Word coinciding with `vs_rise`:**
  - In any state, an `i_de` word in the same cycle as `vs_rise` is the first word of the new frame: x=0, y=0, sof=1.
  - That word is written if the FIFO is not full.
  - If the FIFO is full, it is discarded, `o_ovf` is set, and the state goes to DROP.
- **FIFO:**
  - Synchronous, first-word-fall-through.
  - `full` is evaluated before the same-cycle pop, so a write is refused when full even if a pop occurs that cycle.
  - Pop occurs on `o_tvalid && i_tready`.
  - `o_tvalid = !empty`. `o_tdata`, `o_tuser` and `o_tlast` show the head entry.
- **Handshake:** AXI4-Stream rules.
  - While `o_tvalid && !i_tready`, `o_tdata`, `o_tuser` and `o_tlast` hold stable.
  - `o_tvalid` is never withdrawn without a transfer.
- **Sticky flags:** `o_ovf` and `o_short` are cleared only by reset.

## Timing
- **Reset** (`i_rst_n` low at a rising edge):
  - State → WAIT_SOF; counters 0; FIFO empty; `vs_d` 0.
  - `o_tvalid`, `o_tuser`, `o_tlast`, `o_ovf` and `o_short` are 0 and `o_tdata` is 0 from the next cycle.
  - Reset mid-frame discards all FIFO contents. A new frame needs a fresh `vs_rise`.
- **`vs_rise` timing:** `vs_rise` is visible in the same cycle that `i_vs` is first sampled high. `i_vs` high coming out of reset counts as a rise.
- **Latency:** a word accepted at edge N into an empty FIFO has `o_tvalid=1` after edge N, i.e. 1 cycle.
- **Throughput:** 1 word/cycle in and out. With `i_tready` held high, the FIFO never exceeds 1 entry.
- **Occupancy:** FIFO count = writes − pops. Pointers are log2(FIFO_DEPTH)+1 bits, with wrap handled by the MSB.
- **Flag timing:**
  - `o_ovf` is high the cycle after the dropped word.
  - `o_short` is high the cycle after the early `vs_rise`.

## Test plan
- **Small-frame tagging.** Reset; H_WORDS=4, V_LINES=2, FIFO_DEPTH=8; `i_tready`=1; `vs_rise`, then 8 consecutive words 0..7.
  - Out: 8 beats with data 0..7.
  - `o_tuser` only on beat 0; `o_tlast` on beats 3 and 7; `o_tvalid` first high 1 cycle after the first `i_de`.
- **Pre-VS discard.** 5 `i_de` words with no prior `vs_rise` → no output. Words after the next `vs_rise` start with `o_tuser`=1.
- **Backpressure, no loss.** Same frame with `i_tready`=0 for 8 cycles, then 1.
  - FIFO reaches 8 with no drop and `o_ovf`=0.
  - All 8 words come out in order; `o_tdata` is stable while stalled.
- **Overflow → DROP.** FIFO_DEPTH=8, `i_tready`=0, frame of 12 words.
  - Words 0..7 are stored; word 8 is dropped, `o_ovf`=1, words 9..11 are discarded.
  - After `i_tready`=1, exactly 8 beats are output.
  - The next `vs_rise` frame outputs normally with `o_tuser`=1.
- **Short frame.** `vs_rise` after 5 of 8 words, together with `i_de`.
  - `o_short`=1; that word carries `o_tuser`=1.
  - The new frame's `o_tlast` falls on its 4th word.
- **Mid-stream reset.** Assert `i_rst_n`=0 with 3 words queued.
  - Next cycle: `o_tvalid`=0, flags 0.
  - Further `i_de` is ignored until `vs_rise`.
